// File: rtl/delay_arbiter.sv
// delay_arbiter: round-robin sharing of one prescaled tick source and one
// down-counter among NREQ requesters, each waiting a programmable tick count.
//------------------------------------------------------------------------------
// Module   : delay_arbiter
// Purpose  : Grants one requester at a time, counts its ticks, pulses done.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module delay_arbiter #(
  parameter int NREQ     = 4,
  parameter int LEN_W    = 16,
  parameter int PRESCALE = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*LEN_W-1:0]   len_flat,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    tick
);

  localparam int          IDX_W   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [31:0] PS_LAST = 32'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t            state, state_n;
  logic [NREQ-1:0]   grant_n;
  logic [IDX_W-1:0]  gidx, gidx_n;
  logic [IDX_W-1:0]  rr, rr_n;
  logic [LEN_W-1:0]  remaining, remaining_n;
  logic [31:0]       prescaler, prescaler_n;

  logic              pick_valid;
  logic [IDX_W-1:0]  pick_idx;
  logic [IDX_W:0]    lane_sum;
  logic [IDX_W-1:0]  lane;
  logic [IDX_W-1:0]  gidx_next;
  logic [LEN_W-1:0]  sel_len;
  logic              tick_int;

  // Scan from the highest offset down so the nearest requester above rr wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    lane_sum   = '0;
    lane       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      lane_sum = {1'b0, rr} + (IDX_W+1)'(k);
      if (lane_sum >= (IDX_W+1)'(NREQ)) begin
        lane_sum = lane_sum - (IDX_W+1)'(NREQ);
      end
      lane = lane_sum[IDX_W-1:0];
      if (req[lane]) begin
        pick_valid = 1'b1;
        pick_idx   = lane;
      end
    end
  end

  assign gidx_next = (gidx == IDX_W'(NREQ - 1)) ? '0 : gidx + IDX_W'(1);
  assign sel_len   = len_flat[int'(gidx)*LEN_W +: LEN_W];
  assign tick_int  = (state == COUNT) && (prescaler == PS_LAST);

  always_comb begin
    state_n     = state;
    grant_n     = grant;
    gidx_n      = gidx;
    rr_n        = rr;
    remaining_n = remaining;
    prescaler_n = prescaler;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_n = LOAD;
          gidx_n  = pick_idx;
          grant_n = {{(NREQ-1){1'b0}}, 1'b1} << pick_idx;
        end
      end
      LOAD: begin
        if (!req[gidx]) begin
          state_n = IDLE;
          grant_n = '0;
          rr_n    = gidx_next;
        end else begin
          remaining_n = sel_len;
          prescaler_n = '0;
          state_n     = (sel_len == '0) ? DONE : COUNT;
        end
      end
      COUNT: begin
        // An abort outranks a coincident final tick: no done for a dropped request.
        if (!req[gidx]) begin
          state_n = IDLE;
          grant_n = '0;
          rr_n    = gidx_next;
        end else if (tick_int) begin
          prescaler_n = '0;
          remaining_n = remaining - LEN_W'(1);
          if (remaining == LEN_W'(1)) begin
            state_n = DONE;
          end
        end else begin
          prescaler_n = prescaler + 32'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        rr_n    = gidx_next;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr        <= '0;
      remaining <= '0;
      prescaler <= '0;
    end else begin
      state     <= state_n;
      grant     <= grant_n;
      gidx      <= gidx_n;
      rr        <= rr_n;
      remaining <= remaining_n;
      prescaler <= prescaler_n;
    end
  end

  assign done = (state == DONE) ? grant : '0;
  assign busy = (state != IDLE);
  assign tick = tick_int;

endmodule

`default_nettype wire

// File: tb/tb_delay_arbiter.sv
// tb_delay_arbiter: directed scenario bench for delay_arbiter (PRESCALE=4).
`default_nettype none

module tb_delay_arbiter;

  localparam int NREQ     = 4;
  localparam int LEN_W    = 16;
  localparam int PRESCALE = 4;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [NREQ-1:0]       req;
  logic [NREQ*LEN_W-1:0] len_flat;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic                  tick;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  delay_arbiter #(
    .NREQ     (NREQ),
    .LEN_W    (LEN_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .len_flat (len_flat),
    .grant    (grant),
    .done     (done),
    .busy     (busy),
    .tick     (tick)
  );

  // One clock edge, then observe at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_len(input int lane, input int v);
    len_flat[lane*LEN_W +: LEN_W] = 16'(v);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req   = '0;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NREQ; k++) set_len(k, 5);
    reset = 1'b1;
    req   = 4'b1111;
    for (int k = 1; k <= 2; k++) begin
      step();
      total++;
      if ({grant, done, busy, tick} !== 10'b0) begin
        bad++;
        $display("FAIL reset k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, 10'b0);
      end
    end
    reset = 1'b0;
    req   = '0;
  endtask

  task automatic test_single();
    logic [3:0] eg, ed;
    logic       eb, et;
    set_len(1, 3);
    req = 4'b0010;
    for (int k = 1; k <= 16; k++) begin
      step();
      eg = (k <= 14) ? 4'b0010 : 4'b0000;
      ed = (k == 14) ? 4'b0010 : 4'b0000;
      eb = (k <= 14);
      et = (k == 5) || (k == 9) || (k == 13);
      total++;
      if ({grant, done, busy, tick} !== {eg, ed, eb, et}) begin
        bad++;
        $display("FAIL single k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, {eg, ed, eb, et});
      end
      if (k == 14) req = '0;
    end
  endtask

  // Entered with the rr pointer at 2 (left by test_single).
  task automatic test_reset_mid();
    logic [3:0] eg, ed;
    logic       eb, et;
    set_len(1, 3);
    req = 4'b0010;
    for (int k = 1; k <= 23; k++) begin
      step();
      if (k <= 7) begin
        eg = 4'b0010; ed = 4'b0000; eb = 1'b1; et = (k == 5);
      end else if (k == 8) begin
        eg = 4'b0000; ed = 4'b0000; eb = 1'b0; et = 1'b0;
      end else begin
        eg = (k <= 22) ? 4'b0001 : 4'b0000;
        ed = (k == 22) ? 4'b0001 : 4'b0000;
        eb = (k <= 22);
        et = (k == 13) || (k == 17) || (k == 21);
      end
      total++;
      if ({grant, done, busy, tick} !== {eg, ed, eb, et}) begin
        bad++;
        $display("FAIL reset_mid k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, {eg, ed, eb, et});
      end
      if (k == 7) begin
        reset = 1'b1;
        req   = 4'b0101;
        set_len(0, 3);
        set_len(2, 3);
      end
      if (k == 8)  reset = 1'b0;
      if (k == 22) req = '0;
    end
  endtask

  task automatic test_two();
    logic [3:0] eg, ed;
    logic       eb, et;
    apply_reset();
    set_len(0, 2);
    set_len(2, 2);
    req = 4'b0101;
    for (int k = 1; k <= 22; k++) begin
      step();
      eg = (k <= 10) ? 4'b0001 : ((k >= 12 && k <= 21) ? 4'b0100 : 4'b0000);
      ed = (k == 10) ? 4'b0001 : ((k == 21) ? 4'b0100 : 4'b0000);
      eb = (eg != 4'b0000);
      et = (k == 5) || (k == 9) || (k == 16) || (k == 20);
      total++;
      if ({grant, done, busy, tick} !== {eg, ed, eb, et}) begin
        bad++;
        $display("FAIL two k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, {eg, ed, eb, et});
      end
      if (k == 10) req = 4'b0100;
      if (k == 21) req = '0;
    end
  endtask

  // Each service with len=1 takes 7 cycles: LOAD, 4x COUNT, DONE, IDLE.
  task automatic test_all();
    logic [3:0] eg, ed;
    logic       eb, et;
    int         b, o;
    apply_reset();
    for (int k = 0; k < NREQ; k++) set_len(k, 1);
    req = 4'b1111;
    for (int k = 1; k <= 35; k++) begin
      step();
      b  = (k - 1) / 7;
      o  = (k - 1) % 7;
      eg = (o <= 5) ? 4'(1 << (b % 4)) : 4'b0000;
      ed = (o == 5) ? 4'(1 << (b % 4)) : 4'b0000;
      eb = (o <= 5);
      et = (o == 4);
      total++;
      if ({grant, done, busy, tick} !== {eg, ed, eb, et}) begin
        bad++;
        $display("FAIL all_rr k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, {eg, ed, eb, et});
      end
    end
    req = '0;
  endtask

  task automatic test_zero_len();
    logic [3:0] eg, ed;
    logic       eb;
    apply_reset();
    set_len(3, 0);
    req = 4'b1000;
    for (int k = 1; k <= 4; k++) begin
      step();
      eg = (k <= 2) ? 4'b1000 : 4'b0000;
      ed = (k == 2) ? 4'b1000 : 4'b0000;
      eb = (k <= 2);
      total++;
      if ({grant, done, busy, tick} !== {eg, ed, eb, 1'b0}) begin
        bad++;
        $display("FAIL zero_len k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, {eg, ed, eb, 1'b0});
      end
      if (k == 2) req = '0;
    end
  endtask

  task automatic test_abort();
    logic [3:0] eg, ed;
    logic       eb, et;
    apply_reset();
    set_len(2, 5);
    set_len(3, 1);
    req = 4'b1100;
    for (int k = 1; k <= 14; k++) begin
      step();
      eg = (k <= 6) ? 4'b0100 : ((k >= 8 && k <= 13) ? 4'b1000 : 4'b0000);
      ed = (k == 13) ? 4'b1000 : 4'b0000;
      eb = (eg != 4'b0000);
      et = (k == 5) || (k == 12);
      total++;
      if ({grant, done, busy, tick} !== {eg, ed, eb, et}) begin
        bad++;
        $display("FAIL abort k=%0d got g/d/b/t=%b want=%b", k, {grant, done, busy, tick}, {eg, ed, eb, et});
      end
      if (k == 6)  req = 4'b1000;
      if (k == 13) req = '0;
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    len_flat = '0;
    test_reset();
    test_single();
    test_reset_mid();
    test_two();
    test_all();
    test_zero_len();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
